// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - command codes, scheduler state type and default queue depth
package lcd_pkg;

    localparam int DEPTH_DEFAULT = 4;

    localparam logic [3:0] CMD_WRITE       = 4'd0;
    localparam logic [3:0] CMD_SHIFT_UP    = 4'd1;
    localparam logic [3:0] CMD_SHIFT_DOWN  = 4'd2;
    localparam logic [3:0] CMD_SHIFT_LEFT  = 4'd3;
    localparam logic [3:0] CMD_SHIFT_RIGHT = 4'd4;
    localparam logic [3:0] CMD_MAX         = 4'd5;
    localparam logic [3:0] CMD_MIN         = 4'd6;
    localparam logic [3:0] CMD_AVG         = 4'd7;
    localparam logic [3:0] CMD_ROT_CCW     = 4'd8;
    localparam logic [3:0] CMD_ROT_CW      = 4'd9;
    localparam logic [3:0] CMD_MIRROR_X    = 4'd10;
    localparam logic [3:0] CMD_MIRROR_Y    = 4'd11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP_WAIT,
        WR_WAIT,
        HALT
    } sched_state_t;

    function automatic logic is_illegal(input logic [3:0] code);
        return code > CMD_MIRROR_Y;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - synchronous command FIFO with full/empty/level
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [3:0]    push_data,
    input  logic          pop,
    output logic [3:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// rtl/lcd_cmd_sched.sv - LCD command scheduler; optional LCD_SCHED_ILLEGAL_CHK_EN filters codes 12-15
module lcd_cmd_sched #(
    parameter int DEPTH = lcd_pkg::DEPTH_DEFAULT,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [3:0]               lcd_cmd,
    output logic                     lcd_cmd_valid,
    input  logic                     lcd_busy,
    input  logic                     lcd_done,
    output logic [$clog2(DEPTH):0]   q_level,
    output logic [7:0]               issued_cnt,
    output logic                     err_illegal,
    output logic                     sched_done
);

    import lcd_pkg::*;

    sched_state_t state;
    logic [1:0]   gap_cnt;
    logic         fifo_full;
    logic         fifo_empty;
    logic [3:0]   fifo_head;
    logic         accept;
    logic         push;
    logic         pop;

    assign host_ready = !fifo_full && (state != HALT) && (state != WR_WAIT);
    assign accept     = host_valid && host_ready;
    // The issue decision is taken in IDLE so a busy engine is never handed a command
    assign pop        = (state == IDLE) && !fifo_empty && !lcd_busy;

`ifdef LCD_SCHED_ILLEGAL_CHK_EN
    assign push = accept && !is_illegal(host_cmd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_illegal <= 1'b0;
        end else if (accept && is_illegal(host_cmd)) begin
            err_illegal <= 1'b1;
        end
    end
`else
    assign push        = accept;
    assign err_illegal = 1'b0;
`endif

    lcd_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (host_cmd),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (q_level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            gap_cnt       <= 2'd0;
            lcd_cmd       <= 4'd0;
            lcd_cmd_valid <= 1'b0;
            issued_cnt    <= 8'd0;
            sched_done    <= 1'b0;
        end else begin
            lcd_cmd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state         <= ISSUE;
                        lcd_cmd       <= fifo_head;
                        lcd_cmd_valid <= 1'b1;
                        if (issued_cnt != 8'hFF) begin
                            issued_cnt <= issued_cnt + 8'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (lcd_cmd == CMD_WRITE) begin
                        state <= WR_WAIT;
                    end else if (GAP > 0) begin
                        state   <= GAP_WAIT;
                        gap_cnt <= 2'(GAP - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP_WAIT: begin
                    if (gap_cnt == 2'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
                end
                WR_WAIT: begin
                    if (lcd_done) begin
                        state      <= HALT;
                        sched_done <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// tb/tb_lcd_cmd_sched.sv - directed self-checking bench for lcd_cmd_sched (DEPTH=4, GAP=1)
module tb_lcd_cmd_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] host_cmd;
    logic       host_valid;
    logic       host_ready;
    logic [3:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic       lcd_busy;
    logic       lcd_done;
    logic [2:0] q_level;
    logic [7:0] issued_cnt;
    logic       err_illegal;
    logic       sched_done;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int exp_issued = 0;
    int exp_log    = 0;

    logic [3:0] log_cmd [$];
    int         log_cyc [$];

    lcd_cmd_sched #(
        .DEPTH (4),
        .GAP   (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .host_cmd      (host_cmd),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .lcd_cmd       (lcd_cmd),
        .lcd_cmd_valid (lcd_cmd_valid),
        .lcd_busy      (lcd_busy),
        .lcd_done      (lcd_done),
        .q_level       (q_level),
        .issued_cnt    (issued_cnt),
        .err_illegal   (err_illegal),
        .sched_done    (sched_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lcd_cmd_valid) begin
            log_cmd.push_back(lcd_cmd);
            log_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] c);
        host_cmd   = c;
        host_valid = 1'b1;
        step(1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_q_level"},    q_level,       0);
        check({tag, "_issued"},     issued_cnt,    0);
        check({tag, "_lcd_cmd"},    lcd_cmd,       0);
        check({tag, "_valid"},      lcd_cmd_valid, 0);
        check({tag, "_err"},        err_illegal,   0);
        check({tag, "_sched_done"}, sched_done,    0);
    endtask

    initial begin
        reset      = 1'b0;
        host_cmd   = 4'd0;
        host_valid = 1'b0;
        lcd_busy   = 1'b0;
        lcd_done   = 1'b0;
        step(3);
        check_reset_values("rst");
        reset = 1'b1;
        step(1);
        check("rst_host_ready", host_ready, 1);

        // three commands back to back, engine free
        push(4'd3);
        push(4'd1);
        check("t1_first_valid", lcd_cmd_valid, 1);
        check("t1_first_cmd",   lcd_cmd,       3);
        push(4'd5);
        check("t1_level_push_pop", q_level, 2);
        host_valid = 1'b0;
        step(12);
        exp_issued = 3;
        exp_log    = 3;
        check("t1_log_size", log_cmd.size(), exp_log);
        check("t1_cmd0", log_cmd[0], 3);
        check("t1_cmd1", log_cmd[1], 1);
        check("t1_cmd2", log_cmd[2], 5);
        check("t1_spacing01", log_cyc[1] - log_cyc[0], 3);
        check("t1_spacing12", log_cyc[2] - log_cyc[1], 3);
        check("t1_issued", issued_cnt, exp_issued);
        check("t1_hold_cmd", lcd_cmd, 5);
        check("t1_hold_valid", lcd_cmd_valid, 0);

        // engine busy holds the queue
        lcd_busy = 1'b1;
        push(4'd2);
        push(4'd4);
        host_valid = 1'b0;
        step(5);
        check("t2_no_issue", log_cmd.size(), exp_log);
        check("t2_level", q_level, 2);
        lcd_busy = 1'b0;
        step(1);
        check("t2_issue_valid", lcd_cmd_valid, 1);
        check("t2_issue_cmd",   lcd_cmd,       2);
        step(10);
        exp_issued = 5;
        exp_log    = 5;
        check("t2_log_size", log_cmd.size(), exp_log);
        check("t2_last_cmd", log_cmd[4], 4);
        check("t2_issued", issued_cnt, exp_issued);
        check("t2_level_empty", q_level, 0);

        // fill the queue without draining
        lcd_busy = 1'b1;
        push(4'd1);
        push(4'd2);
        push(4'd3);
        check("t3_ready_at3", host_ready, 1);
        push(4'd4);
        check("t3_ready_full", host_ready, 0);
        check("t3_level_full", q_level, 4);
        push(4'd6);
        check("t3_level_after5", q_level, 4);
        host_valid = 1'b0;
        lcd_busy   = 1'b0;
        step(16);
        exp_issued = 9;
        exp_log    = 9;
        check("t3_log_size", log_cmd.size(), exp_log);
        check("t3_first", log_cmd[5], 1);
        check("t3_last", log_cmd[8], 4);
        check("t3_issued", issued_cnt, exp_issued);
        check("t3_ready_drained", host_ready, 1);

        // illegal code 13
        push(4'd13);
        host_valid = 1'b0;
        step(6);
`ifdef LCD_SCHED_ILLEGAL_CHK_EN
        check("t4_err", err_illegal, 1);
        check("t4_level", q_level, 0);
        check("t4_log_size", log_cmd.size(), exp_log);
`else
        exp_issued = 10;
        exp_log    = 10;
        check("t4_err", err_illegal, 0);
        check("t4_log_size", log_cmd.size(), exp_log);
        check("t4_cmd", log_cmd[exp_log-1], 13);
        check("t4_lcd_cmd", lcd_cmd, 13);
`endif
        check("t4_issued", issued_cnt, exp_issued);

        // write then avg: avg must stay queued after halt
        push(4'd0);
        push(4'd7);
        host_valid = 1'b0;
        step(4);
        exp_issued = exp_issued + 1;
        exp_log    = exp_log + 1;
        check("t5_log_size", log_cmd.size(), exp_log);
        check("t5_write_cmd", log_cmd[exp_log-1], 0);
        check("t5_level_wait", q_level, 1);
        check("t5_ready_wait", host_ready, 0);
        check("t5_done_wait", sched_done, 0);
        lcd_done = 1'b1;
        step(1);
        lcd_done = 1'b0;
        step(1);
        check("t5_sched_done", sched_done, 1);
        check("t5_level_halt", q_level, 1);
        step(8);
        check("t5_no_issue", log_cmd.size(), exp_log);
        check("t5_issued", issued_cnt, exp_issued);
        check("t5_ready_halt", host_ready, 0);

        // reset while waiting on a write with two queued
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        push(4'd0);
        push(4'd1);
        push(4'd2);
        host_valid = 1'b0;
        step(2);
        exp_log = exp_log + 1;
        check("t6_log_size", log_cmd.size(), exp_log);
        check("t6_level_wait", q_level, 2);
        check("t6_ready_wait", host_ready, 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("t6_async");
        step(1);
        reset = 1'b1;
        step(1);
        check("t6_ready_release", host_ready, 1);
        step(8);
        check("t6_no_issue", log_cmd.size(), exp_log);
        check("t6_level_after", q_level, 0);
        check("t6_issued_after", issued_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
